dma_copier: RTL and testbench

- Memory-to-memory word copy engine that acts as a second host (initiator) on the system bus, alongside the core data port.
- Software programs it through a device (responder) register window on the same bus.
- Its host port issues word reads, then writes, using the standard req/gnt/rvalid protocol.
- Raises an interrupt on completion or on a bus error.

---
 rtl/dma_copier_pkg.sv | 31 +++
 rtl/dma_copier_regs.sv | 178 +++++++++++++++++
 rtl/dma_copier.sv | 171 +++++++++++++++++
 tb/tb_dma_copier.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copier_pkg.sv
// dma_copier_pkg
//   Shared definitions for the DMA copy engine: register index decode
//   (cfg_addr_i[4:2]), CTRL/STATUS bit positions and the FSM state type.
package dma_copier_pkg;

  // Register word indices (byte offset >> 2)
  localparam logic [2:0] REG_SRC    = 3'd0;  // 0x00
  localparam logic [2:0] REG_DST    = 3'd1;  // 0x04
  localparam logic [2:0] REG_LEN    = 3'd2;  // 0x08
  localparam logic [2:0] REG_CTRL   = 3'd3;  // 0x0C
  localparam logic [2:0] REG_STATUS = 3'd4;  // 0x10

  // CTRL bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IE_BIT    = 1;

  // STATUS bits
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    ABORT
  } dma_state_e;

endpackage

// File: rtl/dma_copier_regs.sv
// dma_copier_regs
//   Configuration responder of the DMA copy engine: address decode,
//   SRC/DST/LEN/ie/done/err storage, start pulse, W1C handling and the
//   one-cycle cfg response.
//   SRC and DST double as the working pointers; the FSM advances them with
//   ptr_adv_i, so software always reads the live pointer.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   cfg_*                 register window (req/we/be/addr/wdata -> rvalid/rdata/err)
//   busy_i                FSM is not IDLE
//   ptr_adv_i             advance SRC and DST by one word
//   set_done_i/set_err_i  completion / abort flags from the FSM
//   src_o, dst_o, len_o   current register values
//   start_o               accepted start request (single cycle)
//   irq_o                 (done | err) & ie
module dma_copier_regs
  import dma_copier_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_req_i,
  input  logic                    cfg_we_i,
  input  logic [3:0]              cfg_be_i,
  input  logic [AddressWidth-1:0] cfg_addr_i,
  input  logic [DataWidth-1:0]    cfg_wdata_i,
  output logic                    cfg_rvalid_o,
  output logic [DataWidth-1:0]    cfg_rdata_o,
  output logic                    cfg_err_o,
  input  logic                    busy_i,
  input  logic                    ptr_adv_i,
  input  logic                    set_done_i,
  input  logic                    set_err_i,
  output logic [AddressWidth-1:0] src_o,
  output logic [AddressWidth-1:0] dst_o,
  output logic [LenWidth-1:0]     len_o,
  output logic                    start_o,
  output logic                    irq_o
);

  logic [AddressWidth-1:0] src_q, src_d;
  logic [AddressWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]     len_q, len_d;
  logic                    ie_q, ie_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    rvalid_q, rvalid_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    rerr_q, rerr_d;
  logic                    start;

  logic [2:0] reg_idx;
  logic       mapped;
  logic       unused_cfg;

  assign reg_idx    = cfg_addr_i[4:2];
  assign mapped     = (reg_idx <= REG_STATUS);
  // Byte enables and address bits outside [4:2] take no part in decode.
  assign unused_cfg = ^{cfg_be_i, cfg_addr_i[AddressWidth-1:5], cfg_addr_i[1:0]};

  // NOTE: every signal gets its default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    ie_d     = ie_q;
    done_d   = done_q;
    err_d    = err_q;
    rvalid_d = cfg_req_i;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    start    = 1'b0;

    if (ptr_adv_i) begin
      src_d = src_q + AddressWidth'(4);
      dst_d = dst_q + AddressWidth'(4);
    end

    if (cfg_req_i) begin
      if (!mapped) begin
        rerr_d = 1'b1;
      end else if (cfg_we_i) begin
        case (reg_idx)
          REG_SRC: begin
            if (busy_i) rerr_d = 1'b1;
            else        src_d  = AddressWidth'(cfg_wdata_i) & ~AddressWidth'(3);
          end
          REG_DST: begin
            if (busy_i) rerr_d = 1'b1;
            else        dst_d  = AddressWidth'(cfg_wdata_i) & ~AddressWidth'(3);
          end
          REG_LEN: begin
            if (busy_i) rerr_d = 1'b1;
            else        len_d  = cfg_wdata_i[LenWidth-1:0];
          end
          REG_CTRL: begin
            ie_d  = cfg_wdata_i[CTRL_IE_BIT];
            // A start while busy is silently dropped.
            start = cfg_wdata_i[CTRL_START_BIT] & ~busy_i;
          end
          REG_STATUS: begin
            if (cfg_wdata_i[STAT_DONE_BIT]) done_d = 1'b0;
            if (cfg_wdata_i[STAT_ERR_BIT])  err_d  = 1'b0;
          end
          default: rerr_d = 1'b1;
        endcase
      end else begin
        case (reg_idx)
          REG_SRC:    rdata_d = DataWidth'(src_q);
          REG_DST:    rdata_d = DataWidth'(dst_q);
          REG_LEN:    rdata_d = DataWidth'(len_q);
          REG_CTRL:   rdata_d[CTRL_IE_BIT] = ie_q;
          REG_STATUS: begin
            rdata_d[STAT_BUSY_BIT] = busy_i;
            rdata_d[STAT_DONE_BIT] = done_q;
            rdata_d[STAT_ERR_BIT]  = err_q;
          end
          default: rdata_d = '0;
        endcase
      end
    end

    // A zero-length start completes immediately; otherwise it begins a fresh
    // transfer with clean flags.
    if (start) begin
      if (len_q == '0) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    end

    // Hardware sets are applied last so they win over a same-cycle W1C.
    if (set_done_i) done_d = 1'b1;
    if (set_err_i)  err_d  = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = rerr_q;
  assign src_o        = src_q;
  assign dst_o        = dst_q;
  assign len_o        = len_q;
  assign start_o      = start;
  assign irq_o        = (done_q | err_q) & ie_q;

endmodule

// File: rtl/dma_copier.sv
// dma_copier
//   Memory-to-memory word copy engine. A register window (cfg_*) programs
//   SRC, DST and LEN; a start moves LEN words from SRC to DST over the host
//   port, one read then one write per word, a single transaction in flight.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   cfg_*          register responder port (see dma_copier_regs)
//   host_*         bus initiator port, req/gnt/rvalid protocol
//   irq_o          level interrupt (done | err) & ie
module dma_copier
  import dma_copier_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_req_i,
  input  logic                    cfg_we_i,
  input  logic [3:0]              cfg_be_i,
  input  logic [AddressWidth-1:0] cfg_addr_i,
  input  logic [DataWidth-1:0]    cfg_wdata_i,
  output logic                    cfg_rvalid_o,
  output logic [DataWidth-1:0]    cfg_rdata_o,
  output logic                    cfg_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    irq_o
);

  dma_state_e state_q, state_d;

  logic [LenWidth-1:0]     count_q, count_d;
  logic [DataWidth-1:0]    buf_q, buf_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [3:0]              be_q;

  logic [AddressWidth-1:0] src_ptr, dst_ptr;
  logic [LenWidth-1:0]     len;
  logic                    start;
  logic                    busy;
  logic                    ptr_adv;
  logic                    set_done;
  logic                    set_err;

  assign busy = (state_q != IDLE);

  dma_copier_regs #(
    .DataWidth   (DataWidth),
    .AddressWidth(AddressWidth),
    .LenWidth    (LenWidth)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_req_i   (cfg_req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_be_i    (cfg_be_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o (cfg_rdata_o),
    .cfg_err_o   (cfg_err_o),
    .busy_i      (busy),
    .ptr_adv_i   (ptr_adv),
    .set_done_i  (set_done),
    .set_err_i   (set_err),
    .src_o       (src_ptr),
    .dst_o       (dst_ptr),
    .len_o       (len),
    .start_o     (start),
    .irq_o       (irq_o)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    buf_d    = buf_q;
    ptr_adv  = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Late responses arriving here are ignored by construction.
        if (start && (len != '0)) begin
          count_d = len;
          state_d = RD_REQ;
        end
      end
      RD_REQ:  if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (host_rvalid_i) begin
          buf_d   = host_rdata_i;
          state_d = host_err_i ? ABORT : WR_REQ;
        end
      end
      WR_REQ:  if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            state_d = ABORT;
          end else begin
            ptr_adv = 1'b1;
            count_d = count_q - LenWidth'(1);
            if (count_q == LenWidth'(1)) begin
              set_done = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      ABORT: begin
        set_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Host outputs are registered from the next state so req/addr/we change
    // only on an edge and stay frozen while a request waits for its grant.
    // The read address must see the pointer advance happening on this edge.
    req_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
    we_d   = (state_d == WR_REQ);
    addr_d = addr_q;
    if (state_d == RD_REQ) begin
      addr_d = ptr_adv ? (src_ptr + AddressWidth'(4)) : src_ptr;
    end else if (state_d == WR_REQ) begin
      addr_d = dst_ptr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      buf_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      // Full-word access only; zero solely while in reset.
      be_q    <= 4'hF;
    end
  end

  assign host_req_o   = req_q;
  assign host_we_o    = we_q;
  assign host_addr_o  = addr_q;
  assign host_be_o    = be_q;
  assign host_wdata_o = buf_q;

endmodule

// File: tb/tb_dma_copier.sv
module tb_dma_copier;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req_i, cfg_we_i;
  logic [3:0]  cfg_be_i;
  logic [31:0] cfg_addr_i, cfg_wdata_i;
  logic        cfg_rvalid_o, cfg_err_o;
  logic [31:0] cfg_rdata_o;
  logic        host_req_o, host_gnt_i, host_we_o, host_rvalid_i, host_err_i;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;
  logic        irq_o;

  always #5 clk = ~clk;

  dma_copier dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_req_i    (cfg_req_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_be_i     (cfg_be_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .cfg_err_o    (cfg_err_o),
    .host_req_o   (host_req_o),
    .host_gnt_i   (host_gnt_i),
    .host_addr_o  (host_addr_o),
    .host_we_o    (host_we_o),
    .host_be_o    (host_be_o),
    .host_wdata_o (host_wdata_o),
    .host_rvalid_i(host_rvalid_i),
    .host_rdata_i (host_rdata_i),
    .host_err_i   (host_err_i),
    .irq_o        (irq_o)
  );

  localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08,
                          A_CTRL = 32'h0C, A_STATUS = 32'h10, A_BAD = 32'h14;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } bus_txn_t;
  typedef struct packed { logic [31:0] data; logic err; } cfg_rsp_t;

  bus_txn_t    bus_q[$];
  cfg_rsp_t    cfg_q[$];
  string       cfg_name_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;

  // Responder knobs
  int stall_rd = 0, stall_wr = 0, resp_lat = 1;
  int err_read_no = 0, read_no = 0, req_cycles = 0;
  bit stray = 1'b0;

  // Responder state
  bit          pending = 1'b0;
  int          resp_cnt = 0, stall_cnt = 0;
  logic [31:0] resp_data = '0, cap_addr = '0, cap_wdata = '0;
  logic        resp_err = 1'b0, cap_we = 1'b0;
  logic        cfg_req_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Bus memory model + scoreboard for host transactions
  initial begin
    host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
    forever begin
      @(negedge clk);
      host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
      if (rst) begin
        pending = 0; stall_cnt = 0;
      end else if (stray) begin
        host_rvalid_i = 1; host_err_i = 1; host_rdata_i = 32'hDEAD_BEEF;
      end else if (pending) begin
        if (resp_cnt == 0) begin
          host_rvalid_i = 1; host_rdata_i = resp_data; host_err_i = resp_err;
          pending = 0;
        end else resp_cnt--;
      end else if (host_req_o) begin
        req_cycles++;
        if (stall_cnt == 0) begin
          cap_addr = host_addr_o; cap_we = host_we_o; cap_wdata = host_wdata_o;
        end else begin
          check("stall_addr_stable", host_addr_o, cap_addr);
          check("stall_we_stable", host_we_o, cap_we);
          check("stall_wdata_stable", host_wdata_o, cap_wdata);
        end
        if (stall_cnt < (host_we_o ? stall_wr : stall_rd)) begin
          stall_cnt++;
        end else begin
          bus_txn_t e;
          host_gnt_i = 1; stall_cnt = 0;
          if (bus_q.size() == 0) begin
            check("bus_unexpected_txn", 32'd1, 32'd0);
          end else begin
            e = bus_q.pop_front();
            check("bus_we", host_we_o, e.we);
            check("bus_addr", host_addr_o, e.addr);
            check("bus_be", host_be_o, 32'hF);
            if (e.we) check("bus_wdata", host_wdata_o, e.data);
          end
          if (host_we_o) begin
            mem[host_addr_o] = host_wdata_o;
            resp_data = '0; resp_err = 0;
          end else begin
            read_no++;
            resp_data = mem.exists(host_addr_o) ? mem[host_addr_o] : 32'h0;
            resp_err  = (read_no == err_read_no);
          end
          pending = 1; resp_cnt = resp_lat - 1;
        end
      end
    end
  end

  // Config response monitor
  always @(posedge clk or posedge rst)
    if (rst) cfg_req_seen <= 1'b0;
    else     cfg_req_seen <= cfg_req_i;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (cfg_rvalid_o || cfg_req_seen)) begin
        check("cfg_rvalid_timing", cfg_rvalid_o, cfg_req_seen);
        if (cfg_rvalid_o) begin
          if (cfg_q.size() == 0) check("cfg_unexpected_rsp", 32'd1, 32'd0);
          else begin
            cfg_rsp_t r;
            string    nm;
            r  = cfg_q.pop_front();
            nm = cfg_name_q.pop_front();
            check({nm, "_rdata"}, cfg_rdata_o, r.data);
            check({nm, "_cfg_err"}, cfg_err_o, r.err);
          end
        end
      end
    end
  end

  task automatic cfg_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input bit exp_err, input string name);
    cfg_rsp_t r;
    r.data = exp_data; r.err = exp_err;
    cfg_q.push_back(r); cfg_name_q.push_back(name);
    cfg_req_i = 1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wdata; cfg_be_i = 4'hF;
    @(negedge clk);
    cfg_req_i = 0; cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit e, input string n);
    cfg_access(1'b1, a, d, 32'h0, e, n);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] x, input bit e, input string n);
    cfg_access(1'b0, a, 32'h0, x, e, n);
  endtask

  // Reference model: a copy of len words is len (read, write) pairs at
  // src+4i / dst+4i; an error on read number err_beat ends it after that read.
  task automatic plan_copy(input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int err_beat);
    bus_txn_t t;
    exp_words.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] a, w;
      a = src + 32'(4 * i);
      w = $urandom;
      mem[a] = w;
      t.we = 0; t.addr = a; t.data = '0; bus_q.push_back(t);
      if (i + 1 == err_beat) break;
      t.we = 1; t.addr = dst + 32'(4 * i); t.data = w; bus_q.push_back(t);
      exp_words.push_back(w);
    end
    read_no = 0; err_read_no = err_beat;
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n = 0;
    while (!irq_o && n < budget) begin @(negedge clk); n++; end
    check({name, "_irq_after_copy"}, irq_o, 32'd1);
    check({name, "_bus_all_issued"}, bus_q.size(), 32'd0);
  endtask

  task automatic check_dst(input logic [31:0] dst, input string name);
    for (int i = 0; i < exp_words.size(); i++) begin
      logic [31:0] a;
      a = dst + 32'(4 * i);
      check({name, "_dst_word"}, mem.exists(a) ? mem[a] : 32'hX, exp_words[i]);
    end
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int err_beat, input string name);
    plan_copy(src, dst, len, err_beat);
    wr(A_SRC, src, 0, {name, "_wr_src"});
    wr(A_DST, dst, 0, {name, "_wr_dst"});
    wr(A_LEN, 32'(len), 0, {name, "_wr_len"});
    wr(A_CTRL, 32'h3, 0, {name, "_start"});
    wait_irq(2000, name);
    check_dst(dst, name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst = 1; cfg_req_i = 0; cfg_we_i = 0; cfg_be_i = '0; cfg_addr_i = '0; cfg_wdata_i = '0;
    #12;
    check("reset_host_req", host_req_o, 0);
    check("reset_host_be", host_be_o, 0);
    check("reset_host_addr", host_addr_o, 0);
    check("reset_cfg_rvalid", cfg_rvalid_o, 0);
    check("reset_irq", irq_o, 0);
    @(negedge clk); rst = 0; @(negedge clk);
    rd(A_SRC, 0, 0, "reset_src");
    rd(A_LEN, 0, 0, "reset_len");
    rd(A_STATUS, 0, 0, "reset_status");

    // Basic 4-word copy, immediate grant, rvalid +1
    run_copy(32'h0010_0000, 32'h0010_1000, 4, 0, "t1");
    check("t1_irq", irq_o, 1);
    rd(A_STATUS, 32'h2, 0, "t1_status");
    rd(A_SRC, 32'h0010_0010, 0, "t1_src_live");
    rd(A_DST, 32'h0010_1010, 0, "t1_dst_live");
    rd(A_LEN, 32'h4, 0, "t1_len");
    rd(A_CTRL, 32'h2, 0, "t1_ctrl");

    // Same copy, 3-cycle grant stalls
    stall_rd = 3; stall_wr = 3;
    run_copy(32'h0010_0000, 32'h0010_1000, 4, 0, "t2");
    stall_rd = 0; stall_wr = 0;

    // LEN=0: immediate done, no bus traffic
    wr(A_STATUS, 32'h2, 0, "t3_clr_done");
    check("t3_irq_cleared", irq_o, 0);
    wr(A_LEN, 0, 0, "t3_len0");
    snap = req_cycles;
    wr(A_CTRL, 32'h3, 0, "t3_start");
    check("t3_irq_done", irq_o, 1);
    rd(A_STATUS, 32'h2, 0, "t3_status");
    repeat (5) @(negedge clk);
    check("t3_no_bus_traffic", 32'(req_cycles - snap), 0);
    wr(A_STATUS, 32'h2, 0, "t3_w1c");
    check("t3_irq_off", irq_o, 0);
    rd(A_STATUS, 32'h0, 0, "t3_status_clr");

    // Bus error on second read response
    run_copy(32'h0010_0000, 32'h0010_1000, 3, 2, "t4");
    rd(A_STATUS, 32'h4, 0, "t4_status_err");
    rd(A_SRC, 32'h0010_0004, 0, "t4_src_fail_beat");
    rd(A_DST, 32'h0010_1004, 0, "t4_dst_fail_beat");
    err_read_no = 0;

    // Register behaviour while busy
    stall_rd = 30;
    plan_copy(32'h0020_0000, 32'h0020_8000, 2, 0);
    wr(A_SRC, 32'h0020_0003, 0, "t5_wr_src_masked");
    rd(A_SRC, 32'h0020_0000, 0, "t5_src_masked");
    wr(A_DST, 32'h0020_8000, 0, "t5_wr_dst");
    wr(A_LEN, 2, 0, "t5_wr_len");
    wr(A_CTRL, 32'h3, 0, "t5_start");
    wr(A_DST, 32'h0000_1234, 1, "t5_busy_wr_dst");
    rd(A_DST, 32'h0020_8000, 0, "t5_dst_unchanged");
    wr(A_LEN, 7, 1, "t5_busy_wr_len");
    wr(A_CTRL, 32'h3, 0, "t5_busy_start");
    rd(A_BAD, 0, 1, "t5_unmapped_rd");
    wr(A_BAD, 32'hFFFF_FFFF, 1, "t5_unmapped_wr");
    rd(A_STATUS, 32'h1, 0, "t5_status_busy");
    stall_rd = 0;
    wait_irq(2000, "t5");
    check_dst(32'h0020_8000, "t5");
    rd(A_LEN, 2, 0, "t5_len_kept");

    // Pointer wrap across 2^32
    run_copy(32'hFFFF_FFF8, 32'h0030_0000, 4, 0, "wrap");
    rd(A_SRC, 32'h0000_0008, 0, "wrap_src");

    // Randomized copies with random stalls and latency
    for (int k = 0; k < 5; k++) begin
      logic [31:0] s, d;
      int l;
      s = $urandom & 32'h0FFF_FFF0;
      d = s | 32'h4000_0000;
      l = $urandom_range(1, 6);
      stall_rd = $urandom_range(0, 2); stall_wr = $urandom_range(0, 2);
      resp_lat = $urandom_range(1, 3);
      run_copy(s, d, l, 0, "rand");
      rd(A_SRC, s + 32'(4 * l), 0, "rand_src_end");
      rd(A_STATUS, 32'h2, 0, "rand_status");
    end
    stall_rd = 0; stall_wr = 0; resp_lat = 1;

    // Reset while a write request is waiting for grant
    stall_wr = 1000;
    plan_copy(32'h0050_0000, 32'h0050_1000, 3, 0);
    wr(A_SRC, 32'h0050_0000, 0, "t6_wr_src");
    wr(A_DST, 32'h0050_1000, 0, "t6_wr_dst");
    wr(A_LEN, 3, 0, "t6_wr_len");
    wr(A_CTRL, 32'h3, 0, "t6_start");
    snap = 0;
    while (!(host_req_o && host_we_o) && snap < 200) begin @(negedge clk); snap++; end
    check("t6_reached_wr_req", 32'(host_req_o && host_we_o), 1);
    #2 rst = 1;
    #1;
    check("t6_req_async_drop", host_req_o, 0);
    check("t6_we_reset", host_we_o, 0);
    check("t6_addr_reset", host_addr_o, 0);
    check("t6_wdata_reset", host_wdata_o, 0);
    check("t6_irq_reset", irq_o, 0);
    bus_q.delete();
    stall_wr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rd(A_SRC, 0, 0, "t6_src_reset");
    rd(A_DST, 0, 0, "t6_dst_reset");
    rd(A_LEN, 0, 0, "t6_len_reset");
    rd(A_CTRL, 0, 0, "t6_ctrl_reset");
    #1 stray = 1;
    @(negedge clk);
    #1 stray = 0;
    repeat (2) @(negedge clk);
    check("t6_stray_no_req", host_req_o, 0);
    rd(A_STATUS, 0, 0, "t6_status_after_stray");
    check("t6_cfg_queue_drained", cfg_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
